// File: rtl/weighted_sum_mixer_if.sv
// ----------------------------------------------------------------------------
// weighted_sum_mixer_if
//
// Purpose : groups the sample-strobe/data bus of weighted_sum_mixer.
// Params  : CHANNELS - number of packed 16-bit input channels.
// Signals : audio_clk_en - one-cycle sample strobe (master -> mixer)
//           in           - CHANNELS*16 packed unsigned samples, channel k at
//                          [16k+15:16k] (master -> mixer)
//           out          - mixed 16-bit unsigned sample (mixer -> master)
//           overrun      - sticky overrun flag (mixer -> master)
// Modports: master (upstream/sink side), slave (the mixer itself).
// ----------------------------------------------------------------------------
interface weighted_sum_mixer_if #(
    parameter int CHANNELS = 4
);
    logic                    audio_clk_en;
    logic [CHANNELS*16-1:0]  in;
    logic [15:0]             out;
    logic                    overrun;

    modport master (
        output audio_clk_en,
        output in,
        input  out,
        input  overrun
    );

    modport slave (
        input  audio_clk_en,
        input  in,
        output out,
        output overrun
    );
endinterface

// File: rtl/weighted_sum_mixer.sv
// ----------------------------------------------------------------------------
// weighted_sum_mixer
//
// Purpose : mixes CHANNELS unsigned 16-bit samples into one 16-bit sample
//           using fixed unsigned Q4.12 gains. Inputs are snapshotted on each
//           audio_clk_en strobe; the weighted sum is accumulated serially,
//           one channel per clock, and the finished result is presented on
//           `out` at the following strobe (one sample period of latency).
//
// Ports   : clk    - system clock
//           reset  - synchronous, active-high reset
//           bus    - weighted_sum_mixer_if.slave (audio_clk_en, in, out,
//                    overrun)
//
// Config  : WEIGHTED_SUM_MIXER_SATURATE_EN - when defined, the shifted sum
//           saturates to 16'hFFFF; otherwise its low 16 bits are kept.
// ----------------------------------------------------------------------------
module weighted_sum_mixer #(
    parameter int                      CLOCK_RATE       = 50000000,
    parameter int                      SAMPLE_RATE      = 48000,
    parameter int                      CHANNELS         = 4,
    parameter logic [CHANNELS*16-1:0]  GAINS_12_SHIFTED = {CHANNELS{16'h1000}}
) (
    input  logic                  clk,
    input  logic                  reset,
    weighted_sum_mixer_if.slave   bus
);

    localparam int ACC_W = 32 + $clog2(CHANNELS);
    localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

    // The serial accumulation needs CHANNELS idle cycles after each strobe.
    generate
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("weighted_sum_mixer: CHANNELS must be in 1..16");
        end
        if (CHANNELS + 1 > CLOCK_RATE / SAMPLE_RATE) begin : g_bad_rate
            $error("weighted_sum_mixer: CHANNELS+1 exceeds clocks per sample");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                  state_q,   state_d;
    logic [ACC_W-1:0]        acc_q,     acc_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [15:0]             result_q,  result_d;
    logic [CHANNELS*16-1:0]  snap_q,    snap_d;
    logic [15:0]             out_q,     out_d;
    logic                    overrun_q, overrun_d;

    logic [15:0]             snap_k;
    logic [15:0]             gain_k;
    logic [31:0]             prod;
    logic [ACC_W-1:0]        acc_sum;

    // Full-width product of the channel selected by the counter.
    always_comb begin
        snap_k  = snap_q[16*cnt_q +: 16];
        gain_k  = GAINS_12_SHIFTED[16*cnt_q +: 16];
        prod    = 32'(snap_k) * 32'(gain_k);
        acc_sum = acc_q + ACC_W'(prod);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        snap_d    = snap_q;
        out_d     = out_q;
        overrun_d = overrun_q;

        if (bus.audio_clk_en) begin
            // Any strobe (re)starts accumulation on fresh inputs; a strobe
            // that interrupts ACCUM flags overrun and leaves `out` alone.
            snap_d  = bus.in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
            if (state_q == ACCUM) begin
                overrun_d = 1'b1;
            end else begin
                out_d = result_q;
            end
        end else if (state_q == ACCUM) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CH) begin
`ifdef WEIGHTED_SUM_MIXER_SATURATE_EN
                // Anything at or above bit 28 means (sum >> 12) > 16'hFFFF.
                result_d = (acc_sum[ACC_W-1:28] != '0) ? 16'hFFFF
                                                       : acc_sum[27:12];
`else
                result_d = acc_sum[27:12];
`endif
                state_d  = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            snap_q    <= '0;
            out_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            snap_q    <= snap_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_weighted_sum_mixer.sv
// ----------------------------------------------------------------------------
// tb_weighted_sum_mixer
//
// Two mixers (unity gains, and gains 0800/2000/0/0) share strobe, reset and
// input data. A sample-level model predicts `out` and `overrun` after every
// clock edge: each strobe either completes the previous sample (enough
// cycles since the last strobe) or overruns it.
// ----------------------------------------------------------------------------
module tb_weighted_sum_mixer;

    localparam int CH = 4;
    localparam logic [CH*16-1:0] GAINS_A = {16'h1000, 16'h1000, 16'h1000, 16'h1000};
    localparam logic [CH*16-1:0] GAINS_B = {16'h0000, 16'h0000, 16'h2000, 16'h0800};

`ifdef WEIGHTED_SUM_MIXER_SATURATE_EN
    localparam logic [15:0] ALL_ONES_A = 16'hFFFF;
    localparam logic [15:0] V2_A       = 16'hFFFF;
`else
    localparam logic [15:0] ALL_ONES_A = 16'hFFFC;
    localparam logic [15:0] V2_A       = 16'h4FFE;
`endif

    logic clk;
    logic rst;
    logic strobe;
    logic [CH*16-1:0] in_v;

    weighted_sum_mixer_if #(.CHANNELS(CH)) bus_a ();
    weighted_sum_mixer_if #(.CHANNELS(CH)) bus_b ();

    assign bus_a.audio_clk_en = strobe;
    assign bus_a.in           = in_v;
    assign bus_b.audio_clk_en = strobe;
    assign bus_b.in           = in_v;

    weighted_sum_mixer #(.CHANNELS(CH), .GAINS_12_SHIFTED(GAINS_A)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    weighted_sum_mixer #(.CHANNELS(CH), .GAINS_12_SHIFTED(GAINS_B)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: gains as plain integers (4096 = 1.0).
    int          gain_a [CH] = '{4096, 4096, 4096, 4096};
    int          gain_b [CH] = '{2048, 8192, 0, 0};
    logic [15:0] res_a, res_b;
    logic [15:0] exp_out_a, exp_out_b;
    bit          exp_ov;
    bit          pend_valid;
    logic [CH*16-1:0] pend;
    int          cyc;
    int          last_cyc;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mix(input logic [CH*16-1:0] v, input bit use_b);
        longint sum;
        sum = 0;
        for (int k = 0; k < CH; k++) begin
            sum += longint'(v[16*k +: 16]) * longint'(use_b ? gain_b[k] : gain_a[k]);
        end
        sum = sum >> 12;
`ifdef WEIGHTED_SUM_MIXER_SATURATE_EN
        if (sum > 65535) return 16'hFFFF;
`endif
        return sum[15:0];
    endfunction

    // One clock: drive at the falling edge, update the model at the rising
    // edge, compare all outputs 1 time unit later.
    task automatic step(input bit s, input bit r, input logic [CH*16-1:0] v);
        strobe = s;
        rst    = r;
        in_v   = v;
        @(posedge clk);
        cyc++;
        if (r) begin
            res_a = '0; res_b = '0;
            exp_out_a = '0; exp_out_b = '0;
            exp_ov = 1'b0;
            pend_valid = 1'b0;
        end else if (s) begin
            if (pend_valid && (cyc - last_cyc) <= CH) begin
                exp_ov = 1'b1;
            end else begin
                if (pend_valid) begin
                    res_a = mix(pend, 1'b0);
                    res_b = mix(pend, 1'b1);
                end
                exp_out_a = res_a;
                exp_out_b = res_b;
            end
            pend       = v;
            pend_valid = 1'b1;
            last_cyc   = cyc;
        end
        #1;
        check("out_a",     32'(bus_a.out),     32'(exp_out_a));
        check("out_b",     32'(bus_b.out),     32'(exp_out_b));
        check("overrun_a", 32'(bus_a.overrun), 32'(exp_ov));
        check("overrun_b", 32'(bus_b.overrun), 32'(exp_ov));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, {$urandom, $urandom});
    endtask

    task automatic strobe_in(input logic [CH*16-1:0] v);
        step(1'b1, 1'b0, v);
    endtask

    localparam logic [CH*16-1:0] V1 = {16'd4000, 16'd3000, 16'd2000, 16'd1000};
    localparam logic [CH*16-1:0] V2 = {16'hFFFF, 16'hFFFF, 16'h1000, 16'h4000};
    localparam logic [CH*16-1:0] V3 = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    initial begin
        strobe = 1'b0; rst = 1'b1; in_v = '0;
        res_a = '0; res_b = '0; exp_out_a = '0; exp_out_b = '0;
        exp_ov = 1'b0; pend_valid = 1'b0; pend = '0;
        cyc = 0; last_cyc = 0;
        @(negedge clk);

        // Reset state.
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        check("reset_out", 32'(bus_a.out), 32'h0);
        idle(3);

        // Unity gains, 1000..4000: first strobe 0, second 10000.
        strobe_in(V1);
        check("tp1_first", 32'(bus_a.out), 32'h0);
        idle(6);
        strobe_in(V1);
        check("tp1_sum", 32'(bus_a.out), 32'd10000);
        check("tp1_overrun", 32'(bus_a.overrun), 32'h0);

        // Mixed gains and all-ones inputs.
        idle(6);
        strobe_in(V2);
        idle(6);
        strobe_in(V3);
        check("tp2_gains_b", 32'(bus_b.out), 32'h4000);
        check("tp2_v2_a", 32'(bus_a.out), 32'(V2_A));
        idle(6);
        strobe_in(V1);
        check("tp3_all_ones", 32'(bus_a.out), 32'(ALL_ONES_A));

        // Overrun: strobes 3 cycles apart.
        idle(6);
        strobe_in(V3);
        idle(2);
        strobe_in(V2);
        check("ovr_rise", 32'(bus_a.overrun), 32'h1);
        check("ovr_hold", 32'(bus_a.out), 32'd10000);
        idle(2);
        strobe_in(V3);
        check("ovr_hold2", 32'(bus_a.out), 32'd10000);
        idle(6);
        strobe_in(V1);
        check("ovr_resume", 32'(bus_a.out), 32'(ALL_ONES_A));
        idle(6);
        strobe_in(V2);
        check("ovr_resume2", 32'(bus_a.out), 32'd10000);
        check("ovr_sticky", 32'(bus_a.overrun), 32'h1);

        // Reset two cycles into ACCUM.
        idle(6);
        strobe_in(V1);
        idle(1);
        step(1'b0, 1'b1, V3);
        check("rst_accum_out", 32'(bus_a.out), 32'h0);
        check("rst_accum_ovr", 32'(bus_a.overrun), 32'h0);
        idle(3);
        strobe_in(V2);
        check("rst_next_zero", 32'(bus_a.out), 32'h0);
        idle(6);
        strobe_in(V1);
        check("rst_then_sum_b", 32'(bus_b.out), 32'h4000);

        // Strobe and reset together: reset wins.
        idle(6);
        step(1'b1, 1'b1, V1);
        check("rst_wins_out", 32'(bus_a.out), 32'h0);
        idle(6);
        strobe_in(V2);
        check("rst_wins_next", 32'(bus_a.out), 32'h0);

        // Randomized traffic with occasional overruns and resets.
        for (int n = 0; n < 300; n++) begin
            logic [CH*16-1:0] v;
            v = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) v = V3;
            if ($urandom_range(0, 29) == 0) step(1'b0, 1'b1, v);
            strobe_in(v);
            idle(($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3))
                                             : int'($urandom_range(4, 8)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
